// File: rtl/wb_arb_pkg.sv
// Shared types, widths and helpers for the two-master Wishbone BRAM arbiter.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int NB_MASTERS = 2;
   localparam int WB_AW      = 32;
   localparam int WB_DW      = 32;
   localparam int WB_SW      = WB_DW / 8;
   localparam int BURST_W    = 8;

   // One-hot owner vector; all zero while the bus is idle.
   function automatic logic [NB_MASTERS-1:0] grant_of(input arb_state_t st);
      logic [NB_MASTERS-1:0] g;
      case (st)
         OWN0:    g = 2'b01;
         OWN1:    g = 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle; the master drives the request side, the slave answers.
interface wshb_if;
   import wb_arb_pkg::*;

   logic [WB_AW-1:0] adr;
   logic [WB_DW-1:0] dat_ms;
   logic [WB_DW-1:0] dat_sm;
   logic [WB_SW-1:0] sel;
   logic             we;
   logic             cyc;
   logic             stb;
   logic             ack;

   modport master (output adr, dat_ms, sel, we, cyc, stb, input dat_sm, ack);
   modport slave  (input adr, dat_ms, sel, we, cyc, stb, output dat_sm, ack);

endinterface

// File: rtl/wb_arbiter_2m.sv
// Round-robin arbiter sharing one Wishbone BRAM between the display reader (m0)
// and the frame writer (m1); grant is held per cyc, bounded by a burst limit.
module wb_arbiter_2m
   import wb_arb_pkg::*;
#(
   parameter int unsigned MAX_BURST = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   wshb_if.slave                 wb_m0,
   wshb_if.slave                 wb_m1,
   wshb_if.master                wb_s,
   output logic [NB_MASTERS-1:0] grant
);

   localparam logic [BURST_W-1:0] MAX_C = BURST_W'(MAX_BURST);

   arb_state_t         state_q, state_d;
   logic               last_owner_q, last_owner_d;   // 1 = master 1 owned last
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic               mask_q, mask_d;

   logic               req0, req1;
   logic               own_cyc, own_stb, other_req;
   logic [BURST_W-1:0] cnt_inc;

   assign req0 = wb_m0.cyc & wb_m0.stb;
   assign req1 = wb_m1.cyc & wb_m1.stb;

   always_comb begin
      own_cyc   = (state_q == OWN1) ? wb_m1.cyc : wb_m0.cyc;
      own_stb   = (state_q == OWN1) ? wb_m1.stb : wb_m0.stb;
      other_req = (state_q == OWN1) ? req0 : req1;
      cnt_inc   = (burst_cnt_q == MAX_C) ? burst_cnt_q : burst_cnt_q + 1'b1;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      mask_d       = mask_q;
      case (state_q)
         IDLE: begin
            burst_cnt_d = '0;
            mask_d      = 1'b0;
            if (req0 && (!req1 || last_owner_q)) begin
               state_d = OWN0;
            end else if (req1) begin
               state_d = OWN1;
            end
         end
         OWN0, OWN1: begin
            if (!own_cyc || mask_q) begin
               state_d      = IDLE;
               last_owner_d = (state_q == OWN1);
            end else if (wb_s.ack) begin
               burst_cnt_d = cnt_inc;
               if (other_req && cnt_inc == MAX_C) mask_d = 1'b1;
            end else if (other_req && burst_cnt_q == MAX_C && !own_stb) begin
               // Owner has nothing in flight, so yielding cannot split a read.
               mask_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments and clears asynchronously on rst low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         burst_cnt_q  <= '0;
         mask_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         mask_q       <= mask_d;
      end
   end

   // Request routing: idle parks the address side on master 0 with cyc/stb low.
   always_comb begin
      wb_s.adr    = wb_m0.adr;
      wb_s.dat_ms = wb_m0.dat_ms;
      wb_s.sel    = wb_m0.sel;
      wb_s.we     = wb_m0.we;
      wb_s.cyc    = 1'b0;
      wb_s.stb    = 1'b0;
      wb_m0.ack   = 1'b0;
      wb_m1.ack   = 1'b0;
      case (state_q)
         OWN0: begin
            wb_s.cyc  = wb_m0.cyc;
            wb_s.stb  = wb_m0.stb & ~mask_q;
            wb_m0.ack = wb_s.ack;
         end
         OWN1: begin
            wb_s.adr    = wb_m1.adr;
            wb_s.dat_ms = wb_m1.dat_ms;
            wb_s.sel    = wb_m1.sel;
            wb_s.we     = wb_m1.we;
            wb_s.cyc    = wb_m1.cyc;
            wb_s.stb    = wb_m1.stb & ~mask_q;
            wb_m1.ack   = wb_s.ack;
         end
         default: ;
      endcase
   end

   assign wb_m0.dat_sm = wb_s.dat_sm;
   assign wb_m1.dat_sm = wb_s.dat_sm;
   assign grant        = grant_of(state_q);

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench: arbiter A (MAX_BURST=4) and arbiter B (default 16), each on its own BRAM model.
module tb_wb_arbiter_2m;
   import wb_arb_pkg::*;

   logic clk;
   logic rst;

   // Masters 0,1 sit on arbiter A; masters 2,3 on arbiter B.
   logic        m_cyc [4];
   logic        m_stb [4];
   logic        m_we  [4];
   logic [31:0] m_adr [4];
   logic [31:0] m_dat [4];
   logic [3:0]  m_sel [4];
   logic        m_ack [4];
   logic [31:0] m_rdat[4];

   logic        s_cyc [2];
   logic        s_stb [2];
   logic        s_we  [2];
   logic [31:0] s_adr [2];
   logic [31:0] s_dat [2];
   logic [3:0]  s_sel [2];
   logic        s_ack [2];
   logic [31:0] rd_dat[2];
   logic        rd_ack[2];
   logic [31:0] mem   [2][256];

   logic [1:0] a_grant, b_grant;

   int checks = 0;
   int errors = 0;
   int bad_ack = 0;
   int run_a = 0;
   int runs_a[$];
   logic [1:0] hist_a[$];
   logic [1:0] hist_b[$];
   logic [1:0] prev_a = 2'b00;
   logic [1:0] prev_b = 2'b00;

   wshb_if a_m0 ();
   wshb_if a_m1 ();
   wshb_if a_s  ();
   wshb_if b_m0 ();
   wshb_if b_m1 ();
   wshb_if b_s  ();

   assign a_m0.cyc = m_cyc[0]; assign a_m0.stb = m_stb[0]; assign a_m0.we = m_we[0];
   assign a_m0.adr = m_adr[0]; assign a_m0.dat_ms = m_dat[0]; assign a_m0.sel = m_sel[0];
   assign a_m1.cyc = m_cyc[1]; assign a_m1.stb = m_stb[1]; assign a_m1.we = m_we[1];
   assign a_m1.adr = m_adr[1]; assign a_m1.dat_ms = m_dat[1]; assign a_m1.sel = m_sel[1];
   assign b_m0.cyc = m_cyc[2]; assign b_m0.stb = m_stb[2]; assign b_m0.we = m_we[2];
   assign b_m0.adr = m_adr[2]; assign b_m0.dat_ms = m_dat[2]; assign b_m0.sel = m_sel[2];
   assign b_m1.cyc = m_cyc[3]; assign b_m1.stb = m_stb[3]; assign b_m1.we = m_we[3];
   assign b_m1.adr = m_adr[3]; assign b_m1.dat_ms = m_dat[3]; assign b_m1.sel = m_sel[3];

   assign m_ack[0] = a_m0.ack; assign m_rdat[0] = a_m0.dat_sm;
   assign m_ack[1] = a_m1.ack; assign m_rdat[1] = a_m1.dat_sm;
   assign m_ack[2] = b_m0.ack; assign m_rdat[2] = b_m0.dat_sm;
   assign m_ack[3] = b_m1.ack; assign m_rdat[3] = b_m1.dat_sm;

   assign s_cyc[0] = a_s.cyc; assign s_stb[0] = a_s.stb; assign s_we[0] = a_s.we;
   assign s_adr[0] = a_s.adr; assign s_dat[0] = a_s.dat_ms; assign s_sel[0] = a_s.sel;
   assign s_cyc[1] = b_s.cyc; assign s_stb[1] = b_s.stb; assign s_we[1] = b_s.we;
   assign s_adr[1] = b_s.adr; assign s_dat[1] = b_s.dat_ms; assign s_sel[1] = b_s.sel;
   assign s_ack[0] = rd_ack[0] | (s_cyc[0] & s_stb[0] & s_we[0]);
   assign s_ack[1] = rd_ack[1] | (s_cyc[1] & s_stb[1] & s_we[1]);
   assign a_s.ack = s_ack[0]; assign a_s.dat_sm = rd_dat[0];
   assign b_s.ack = s_ack[1]; assign b_s.dat_sm = rd_dat[1];

   wb_arbiter_2m #(.MAX_BURST(4)) dut_a (
      .clk(clk), .rst(rst), .wb_m0(a_m0), .wb_m1(a_m1), .wb_s(a_s), .grant(a_grant)
   );

   wb_arbiter_2m dut_b (
      .clk(clk), .rst(rst), .wb_m0(b_m0), .wb_m1(b_m1), .wb_s(b_s), .grant(b_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: write ack combinational with stb, read ack one cycle later.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ack[0] <= 1'b0;
         rd_ack[1] <= 1'b0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            rd_ack[b] <= s_cyc[b] & s_stb[b] & ~s_we[b] & ~rd_ack[b];
            if (s_cyc[b] & s_stb[b] & ~s_we[b]) rd_dat[b] <= mem[b][s_adr[b][7:0]];
            if (s_cyc[b] & s_stb[b] & s_we[b])
               for (int k = 0; k < 4; k++)
                  if (s_sel[b][k]) mem[b][s_adr[b][7:0]][8*k +: 8] <= s_dat[b][8*k +: 8];
         end
      end
   end

   // Bus monitor: acks outside ownership, BRAM acks while idle, grant history, m1 runs on A.
   always @(negedge clk) begin
      if (m_ack[0] === 1'b1 && a_grant !== 2'b01) bad_ack++;
      if (m_ack[1] === 1'b1 && a_grant !== 2'b10) bad_ack++;
      if (m_ack[2] === 1'b1 && b_grant !== 2'b01) bad_ack++;
      if (m_ack[3] === 1'b1 && b_grant !== 2'b10) bad_ack++;
      if (s_ack[0] === 1'b1 && a_grant === 2'b00) bad_ack++;
      if (s_ack[1] === 1'b1 && b_grant === 2'b00) bad_ack++;
      if (a_grant === 2'b10 && m_ack[1] === 1'b1) run_a++;
      if (a_grant !== prev_a) begin
         hist_a.push_back(a_grant);
         if (prev_a === 2'b10) begin
            runs_a.push_back(run_a);
            run_a = 0;
         end
         prev_a = a_grant;
      end
      if (b_grant !== prev_b) begin
         hist_b.push_back(b_grant);
         prev_b = b_grant;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input int m, input logic we, input logic [31:0] adr,
                       input logic [31:0] wdat, input logic last,
                       output logic [31:0] rdat, output logic ok);
      m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
      m_adr[m] = adr;  m_dat[m] = wdat; m_sel[m] = 4'hF;
      ok = 1'b0;
      rdat = '0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (m_ack[m] === 1'b1) begin
            ok = 1'b1;
            rdat = m_rdat[m];
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      if (last) begin
         m_cyc[m] = 1'b0;
         m_stb[m] = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
         m_adr[i] = '0;   m_dat[i] = '0;   m_sel[i] = 4'hF;
      end
      // Both A masters request during reset; nothing may be granted yet.
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_adr[0] = 32'h4; m_dat[0] = 32'h1111_0000;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 32'h5; m_dat[1] = 32'h2222_0000;
      tick();
      tick();
      @(negedge clk);
      checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL reset_grant_a: got %b want 00", a_grant); end
      checks++; if (b_grant !== 2'b00) begin errors++; $display("FAIL reset_grant_b: got %b want 00", b_grant); end
      checks++; if (s_cyc[0] !== 1'b0 || s_stb[0] !== 1'b0) begin errors++; $display("FAIL reset_bus_a: cyc=%b stb=%b want 0 0", s_cyc[0], s_stb[0]); end
      checks++; if (m_ack[0] !== 1'b0 || m_ack[1] !== 1'b0) begin errors++; $display("FAIL reset_acks_a: m0=%b m1=%b want 0 0", m_ack[0], m_ack[1]); end
      checks++; if (s_cyc[1] !== 1'b0 || s_stb[1] !== 1'b0) begin errors++; $display("FAIL reset_bus_b: cyc=%b stb=%b want 0 0", s_cyc[1], s_stb[1]); end
   endtask

   task automatic test_tie();
      // Release at a negedge with both still requesting: last_owner=1 -> master 0 wins.
      rst = 1'b1;
      #1;
      checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL tie_pre_grant: got %b want 00", a_grant); end
      tick();
      @(negedge clk);
      checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL tie_grant_m0: got %b want 01", a_grant); end
      checks++; if (m_ack[0] !== 1'b1 || m_ack[1] !== 1'b0) begin errors++; $display("FAIL tie_acks: m0=%b m1=%b want 1 0", m_ack[0], m_ack[1]); end
      tick();
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      @(negedge clk);
      checks++; if (a_grant !== 2'b01 || s_cyc[0] !== 1'b0) begin errors++; $display("FAIL tie_drop: grant=%b cyc=%b want 01 0", a_grant, s_cyc[0]); end
      tick();
      @(negedge clk);
      checks++; if (a_grant !== 2'b00 || s_cyc[0] !== 1'b0) begin errors++; $display("FAIL tie_idle_gap: grant=%b cyc=%b want 00 0", a_grant, s_cyc[0]); end
      tick();
      @(negedge clk);
      checks++; if (a_grant !== 2'b10) begin errors++; $display("FAIL tie_grant_m1: got %b want 10", a_grant); end
      checks++; if (m_ack[1] !== 1'b1 || m_ack[0] !== 1'b0) begin errors++; $display("FAIL tie_m1_ack: m0=%b m1=%b want 0 1", m_ack[0], m_ack[1]); end
      tick();
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_single();
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
      m_adr[0] = 32'h10; m_dat[0] = 32'hDEAD_BEEF; m_sel[0] = 4'hF;
      @(negedge clk);
      checks++; if (a_grant !== 2'b00 || m_ack[0] !== 1'b0) begin errors++; $display("FAIL single_req_cycle: grant=%b ack=%b want 00 0", a_grant, m_ack[0]); end
      tick();
      @(negedge clk);
      checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", a_grant); end
      checks++; if (s_stb[0] !== 1'b1 || m_ack[0] !== 1'b1) begin errors++; $display("FAIL single_wr_ack: stb=%b ack=%b want 1 1", s_stb[0], m_ack[0]); end
      tick();
      m_we[0] = 1'b0;
      @(negedge clk);
      checks++; if (s_stb[0] !== 1'b1 || m_ack[0] !== 1'b0) begin errors++; $display("FAIL single_rd_wait: stb=%b ack=%b want 1 0", s_stb[0], m_ack[0]); end
      tick();
      @(negedge clk);
      checks++; if (m_ack[0] !== 1'b1) begin errors++; $display("FAIL single_rd_ack: got %b want 1", m_ack[0]); end
      checks++; if (m_rdat[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rd_data: got %h want deadbeef", m_rdat[0]); end
      tick();
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      tick();
      tick();
      @(negedge clk);
      checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b want 00", a_grant); end
   endtask

   task automatic test_burst_limit();
      logic [31:0] rd;
      logic        ok;
      logic [1:0]  exp_h[6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      for (int i = 0; i < 10; i++) begin
         xfer(1, 1'b1, 32'h20 + i, 32'hC0DE_0000 + i, (i == 9), rd, ok);
      end
      tick();
      tick();
      @(negedge clk);
      hist_a.delete();
      runs_a.delete();
      run_a = 0;
      tick();
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               xfer(1, 1'b0, 32'h20 + i, 32'h0, (i == 9), rd, ok);
               checks++;
               if (ok !== 1'b1 || rd !== 32'hC0DE_0000 + i) begin
                  errors++;
                  $display("FAIL burst_rd_%0d: ok=%b data=%h want 1 %h", i, ok, rd, 32'hC0DE_0000 + i);
               end
            end
         end
         begin
            tick();
            tick();
            xfer(0, 1'b1, 32'h40, 32'h0000_00A0, 1'b0, rd, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL burst_m0_wr0: ack timeout"); end
            xfer(0, 1'b1, 32'h41, 32'h0000_00A1, 1'b1, rd, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL burst_m0_wr1: ack timeout"); end
         end
      join
      tick();
      tick();
      tick();
      checks++;
      if (runs_a.size() != 2) begin
         errors++; $display("FAIL burst_run_count: got %0d runs want 2", runs_a.size());
      end else if (runs_a[0] != 4 || runs_a[1] != 6) begin
         errors++; $display("FAIL burst_runs: got %0d,%0d want 4,6", runs_a[0], runs_a[1]);
      end
      checks++;
      if (hist_a.size() != 6) begin
         errors++; $display("FAIL burst_grant_hist_len: got %0d want 6", hist_a.size());
      end else begin
         for (int i = 0; i < 6; i++)
            if (hist_a[i] !== exp_h[i]) begin
               errors++; $display("FAIL burst_grant_hist_%0d: got %b want %b", i, hist_a[i], exp_h[i]);
               break;
            end
      end
   endtask

   task automatic test_saturate();
      logic [31:0] rd;
      logic        ok;
      int          acks = 0;
      hist_b.delete();
      for (int i = 0; i < 40; i++) begin
         xfer(3, 1'b1, 32'h80 + i, 32'h5A00_0000 + i, 1'b0, rd, ok);
         if (ok === 1'b1) acks++;
         if (i == 9) begin
            checks++; if (dut_b.burst_cnt_q !== 8'd10) begin errors++; $display("FAIL sat_cnt_10: got %0d want 10", dut_b.burst_cnt_q); end
         end
      end
      checks++; if (acks != 40) begin errors++; $display("FAIL sat_acks: got %0d want 40", acks); end
      checks++; if (dut_b.burst_cnt_q !== 8'd16) begin errors++; $display("FAIL sat_cnt: got %0d want 16", dut_b.burst_cnt_q); end
      checks++; if (b_grant !== 2'b10) begin errors++; $display("FAIL sat_still_owned: got %b want 10", b_grant); end
      m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (hist_b.size() != 2 || hist_b[0] !== 2'b10 || hist_b[1] !== 2'b00) begin
         errors++; $display("FAIL sat_no_preempt: %0d grant changes want 2 (10 then 00)", hist_b.size());
      end
   endtask

   task automatic test_reset_mid_read();
      tick();
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h10;
      tick();
      @(negedge clk);
      checks++; if (s_stb[0] !== 1'b1 || m_ack[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pending: stb=%b ack=%b want 1 0", s_stb[0], m_ack[0]); end
      #1;
      rst = 1'b0;
      #1;
      checks++; if (s_stb[0] !== 1'b0 || s_cyc[0] !== 1'b0) begin errors++; $display("FAIL rstmid_bus: cyc=%b stb=%b want 0 0", s_cyc[0], s_stb[0]); end
      checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL rstmid_grant: got %b want 00", a_grant); end
      checks++; if (m_ack[0] !== 1'b0 || m_ack[1] !== 1'b0) begin errors++; $display("FAIL rstmid_acks: m0=%b m1=%b want 0 0", m_ack[0], m_ack[1]); end
      // Master 0 restarts later; master 1 starts a write while reset is held.
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 32'h60; m_dat[1] = 32'h7777_0001;
      tick();
      checks++; if (a_grant !== 2'b00 || m_ack[0] !== 1'b0) begin errors++; $display("FAIL rstmid_hold: grant=%b ack0=%b want 00 0", a_grant, m_ack[0]); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      @(negedge clk);
      checks++; if (a_grant !== 2'b10) begin errors++; $display("FAIL rstmid_regrant: got %b want 10", a_grant); end
      checks++; if (m_ack[1] !== 1'b1 || m_ack[0] !== 1'b0) begin errors++; $display("FAIL rstmid_m1_ack: m0=%b m1=%b want 0 1", m_ack[0], m_ack[1]); end
      tick();
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_tie();
      test_single();
      test_burst_limit();
      test_saturate();
      test_reset_mid_read();
      checks++; if (bad_ack != 0) begin errors++; $display("FAIL stray_acks: got %0d want 0", bad_ack); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
